// File: rtl/neuron_layer_seq.sv
// Time-multiplexed fully-connected layer: one shared signed MAC walks M neurons x N inputs,
// then bias add, shift/saturate quantization and a selectable activation per neuron.
module neuron_layer_seq #(
   parameter int unsigned N          = 4,
   parameter int unsigned M          = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned FRAC_BITS  = 0,
   parameter int unsigned ACC_WIDTH  = 2*DATA_WIDTH + $clog2(N) + 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [N*DATA_WIDTH-1:0]      x,
   input  logic [M*N*DATA_WIDTH-1:0]    w,
   input  logic [M*DATA_WIDTH-1:0]      b,
   input  logic [1:0]                   act_mode,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [M*DATA_WIDTH-1:0]      y,
   output logic                         busy
);

   localparam int unsigned DW = DATA_WIDTH;
   localparam int unsigned PW = 2*DW;
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned JW = (M > 1) ? $clog2(M) : 1;

   localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = {{(ACC_WIDTH-DW+1){1'b0}}, {(DW-1){1'b1}}};
   localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = {{(ACC_WIDTH-DW+1){1'b1}}, {(DW-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

   state_t                       state_q, state_nxt;
   logic [N*DW-1:0]              x_q;
   logic [M*N*DW-1:0]            w_q;
   logic [M*DW-1:0]              b_q;
   logic [1:0]                   mode_q;
   logic [IW-1:0]                i_q;
   logic [JW-1:0]                j_q;
   logic signed [ACC_WIDTH-1:0]  acc_q;
   logic [M*DW-1:0]              y_q;
   logic                         in_ready_q, out_valid_q, busy_q;

   logic                         accept, i_last, last_mac;
   int unsigned                  x_idx, w_idx, b_idx;
   logic signed [DW-1:0]         xi, wji, bj, sat_v, act_v;
   logic signed [PW-1:0]         xe, we, prod;
   logic signed [ACC_WIDTH-1:0]  mac_sum, fin_sum, shifted;

   assign accept   = (state_q == S_IDLE) && in_valid;
   assign i_last   = (i_q == IW'(N-1));
   assign last_mac = i_last && (j_q == JW'(M-1));

   // Shared MAC datapath plus per-neuron finalize (bias, quantize, activate)
   always_comb begin
      x_idx   = 32'(i_q) * DW;
      w_idx   = (32'(j_q) * N + 32'(i_q)) * DW;
      b_idx   = 32'(j_q) * DW;
      xi      = x_q[x_idx +: DW];
      wji     = w_q[w_idx +: DW];
      bj      = b_q[b_idx +: DW];
      xe      = PW'(xi);
      we      = PW'(wji);
      prod    = xe * we;
      mac_sum = acc_q + ACC_WIDTH'(prod);
      fin_sum = mac_sum + ACC_WIDTH'(bj);
      shifted = fin_sum >>> FRAC_BITS;
      if (shifted > SAT_MAX)      sat_v = {1'b0, {(DW-1){1'b1}}};
      else if (shifted < SAT_MIN) sat_v = {1'b1, {(DW-1){1'b0}}};
      else                        sat_v = shifted[DW-1:0];
      case (mode_q)
         2'd0:    act_v = sat_v;
         2'd2:    act_v = sat_v[DW-1] ? (sat_v >>> 3) : sat_v;
         default: act_v = sat_v[DW-1] ? '0 : sat_v;
      endcase
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         S_IDLE:  if (in_valid)  state_nxt = S_MAC;
         S_MAC:   if (last_mac)  state_nxt = S_DONE;
         S_DONE:  if (out_ready) state_nxt = S_IDLE;
         default:                state_nxt = S_IDLE;
      endcase
   end

   // State and handshake flags registered together so they always agree
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         in_ready_q  <= (state_nxt == S_IDLE);
         out_valid_q <= (state_nxt == S_DONE);
         busy_q      <= (state_nxt != S_IDLE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_q    <= '0;
         w_q    <= '0;
         b_q    <= '0;
         mode_q <= '0;
         i_q    <= '0;
         j_q    <= '0;
         acc_q  <= '0;
         y_q    <= '0;
      end else if (accept) begin
         x_q    <= x;
         w_q    <= w;
         b_q    <= b;
         mode_q <= act_mode;
         i_q    <= '0;
         j_q    <= '0;
         acc_q  <= '0;
      end else if (state_q == S_MAC) begin
         if (i_last) begin
            y_q[b_idx +: DW] <= act_v;
            acc_q <= '0;
            i_q   <= '0;
            j_q   <= last_mac ? '0 : j_q + JW'(1);
         end else begin
            acc_q <= mac_sum;
            i_q   <= i_q + IW'(1);
         end
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign y         = y_q;

endmodule

// File: tb/tb_neuron_layer_seq.sv
// Self-checking bench for neuron_layer_seq: directed table, random vectors vs. arithmetic model,
// backpressure, same-edge handshake and mid-MAC reset. A FRAC_BITS=2 twin runs in lockstep.
module tb_neuron_layer_seq;

   localparam int N  = 4;
   localparam int M  = 2;
   localparam int DW = 8;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              in_valid = 1'b0;
   logic              out_ready = 1'b0;
   logic [N*DW-1:0]   x = '0;
   logic [M*N*DW-1:0] w = '0;
   logic [M*DW-1:0]   b = '0;
   logic [1:0]        act_mode = '0;
   logic              in_ready, out_valid, busy;
   logic              in_ready2, out_valid2, busy2;
   logic [M*DW-1:0]   y, y2;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   neuron_layer_seq #(.N(N), .M(M), .DATA_WIDTH(DW), .FRAC_BITS(0)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .x(x), .w(w), .b(b), .act_mode(act_mode),
      .out_valid(out_valid), .out_ready(out_ready), .y(y), .busy(busy));

   neuron_layer_seq #(.N(N), .M(M), .DATA_WIDTH(DW), .FRAC_BITS(2)) dut_f2 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
      .x(x), .w(w), .b(b), .act_mode(act_mode),
      .out_valid(out_valid2), .out_ready(out_ready), .y(y2), .busy(busy2));

   typedef struct {
      logic [N*DW-1:0]   xv;
      logic [M*N*DW-1:0] wv;
      logic [M*DW-1:0]   bv;
      logic [1:0]        mv;
      int                e0, e1;   // FRAC_BITS=0 expectations
      int                f0, f1;   // FRAC_BITS=2 expectations
   } vec_t;

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Reference: exact integer dot product, floor division by 2^frac, clamp, activation
   function automatic int ref_neuron(input logic [N*DW-1:0] xv, input logic [M*N*DW-1:0] wv,
                                     input logic [M*DW-1:0] bv, input logic [1:0] mv,
                                     input int j, input int frac);
      int s, d, r;
      s = 0;
      for (int i = 0; i < N; i++)
         s += int'($signed(xv[i*DW +: DW])) * int'($signed(wv[(j*N+i)*DW +: DW]));
      s += int'($signed(bv[j*DW +: DW]));
      d = 1 << frac;
      r = s % d;
      s = (s - r) / d;
      if (r < 0) s = s - 1;
      if (s > 127)  s = 127;
      if (s < -128) s = -128;
      if (s < 0) begin
         if (mv == 2'd0)      s = s;
         else if (mv == 2'd2) s = (s - 7) / 8;
         else                 s = 0;
      end
      return s;
   endfunction

   function automatic int yj(input logic [M*DW-1:0] yy, input int j);
      return int'($signed(yy[j*DW +: DW]));
   endfunction

   task automatic do_txn(input vec_t v, input string nm, input bit early, input int hold);
      int cyc;
      bit rdy_bad, stable_bad;
      logic [M*DW-1:0] ys;
      @(negedge clk);
      chk({nm, "_in_ready_idle"}, int'(in_ready), 1);
      x = v.xv; w = v.wv; b = v.bv; act_mode = v.mv;
      in_valid = 1'b1;
      out_ready = early;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      x = $urandom; w = {$urandom, $urandom}; b = 16'($urandom); act_mode = 2'($urandom);
      cyc = 1;
      rdy_bad = 1'b0;
      while (!out_valid && cyc < 100) begin
         if (in_ready || !busy) rdy_bad = 1'b1;
         @(negedge clk);
         cyc++;
      end
      chk({nm, "_latency"}, cyc, M*N+1);
      chk({nm, "_busy_during_mac"}, int'(rdy_bad), 0);
      chk({nm, "_y0"}, yj(y, 0), v.e0);
      chk({nm, "_y1"}, yj(y, 1), v.e1);
      chk({nm, "_f2_y0"}, yj(y2, 0), v.f0);
      chk({nm, "_f2_y1"}, yj(y2, 1), v.f1);
      if (!early) begin
         ys = y;
         stable_bad = 1'b0;
         for (int k = 0; k < hold; k++) begin
            in_valid = ~in_valid;
            @(negedge clk);
            if (y !== ys || !out_valid || in_ready || !out_valid2) stable_bad = 1'b1;
         end
         chk({nm, "_hold_stable"}, int'(stable_bad), 0);
         in_valid = 1'b0;
         out_ready = 1'b1;
      end
      @(negedge clk);
      chk({nm, "_out_valid_drop"}, int'(out_valid), 0);
      chk({nm, "_back_to_idle"}, int'(in_ready), 1);
      out_ready = 1'b0;
      @(negedge clk);
      chk({nm, "_no_spurious_accept"}, int'(busy), 0);
   endtask

   vec_t tbl[6];
   vec_t rv;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{32'h04030201, 64'hFFFFFFFF_01010101, 16'h0500, 2'd1, 10,   0,   2,   0};
      tbl[1] = '{32'h04030201, 64'hFFFFFFFF_01010101, 16'h0500, 2'd0, 10,  -5,   2,  -2};
      tbl[2] = '{32'h04030201, 64'hFFFFFFFF_01010101, 16'h0500, 2'd2, 10,  -1,   2,  -1};
      tbl[3] = '{32'h7F7F7F7F, 64'h7F7F7F7F_7F7F7F7F, 16'h0000, 2'd0, 127, 127, 127, 127};
      tbl[4] = '{32'h7F7F7F7F, 64'h80808080_80808080, 16'h0000, 2'd0, -128,-128,-128,-128};
      tbl[5] = '{32'h04030201, 64'hFFFFFFFF_01010101, 16'h0001, 2'd0, 11, -10,   2,  -3};

      repeat (3) @(negedge clk);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_y", int'(y), 0);
      rst_n = 1'b1;

      for (int t = 0; t < 6; t++)
         do_txn(tbl[t], $sformatf("tbl%0d", t), (t == 2), 1);

      // Long backpressure in DONE with in_valid toggling
      do_txn(tbl[3], "backpressure", 1'b0, 10);

      // Reset during the third MAC cycle discards the partial result
      @(negedge clk);
      x = tbl[1].xv; w = tbl[1].wv; b = tbl[1].bv; act_mode = tbl[1].mv;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", int'(out_valid), 0);
      chk("midreset_y", int'(y), 0);
      chk("midreset_f2_y", int'(y2), 0);
      chk("midreset_in_ready", int'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      do_txn(tbl[0], "after_reset", 1'b0, 0);

      for (int r = 0; r < 40; r++) begin
         rv.xv = $urandom;
         rv.wv = {$urandom, $urandom};
         rv.bv = 16'($urandom);
         rv.mv = 2'($urandom);
         if (r % 8 == 0) rv.xv = 32'h80808080;
         rv.e0 = ref_neuron(rv.xv, rv.wv, rv.bv, rv.mv, 0, 0);
         rv.e1 = ref_neuron(rv.xv, rv.wv, rv.bv, rv.mv, 1, 0);
         rv.f0 = ref_neuron(rv.xv, rv.wv, rv.bv, rv.mv, 0, 2);
         rv.f1 = ref_neuron(rv.xv, rv.wv, rv.bv, rv.mv, 1, 2);
         do_txn(rv, $sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
